// File: rtl/core_muldiv_ctrl.sv
// Iterative RV64 M-extension unit: radix-2 shift-add multiplier and restoring divider
// sharing one 128-bit accumulator, with sign fix-up and a one-cycle completion pulse.
module core_muldiv_ctrl #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      alu_ctrl,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            busy,
    output logic            out_valid,
    output logic [XLEN-1:0] result
);

    localparam logic [CNT_W-1:0] LastIter = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MinNeg   = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              is_div_q, is_div_d;
    logic              is_rem_q, is_rem_d;
    logic              is_hi_q, is_hi_d;
    logic              neg_a_q, neg_a_d;
    logic              neg_b_q, neg_b_d;

    // Op decode; MUL and undefined codes with bit 4 set take the defaults.
    logic dec_div, dec_rem, dec_hi, dec_sa, dec_sb;
    always_comb begin
        dec_div = 1'b0;
        dec_rem = 1'b0;
        dec_hi  = 1'b0;
        dec_sa  = 1'b1;
        dec_sb  = 1'b1;
        case (alu_ctrl)
            5'b10001: dec_hi = 1'b1;
            5'b10011: begin dec_hi = 1'b1; dec_sb = 1'b0; end
            5'b10010: begin dec_hi = 1'b1; dec_sa = 1'b0; dec_sb = 1'b0; end
            5'b10110: dec_div = 1'b1;
            5'b10100: begin dec_div = 1'b1; dec_sa = 1'b0; dec_sb = 1'b0; end
            5'b10101: begin dec_div = 1'b1; dec_rem = 1'b1; end
            5'b10111: begin dec_div = 1'b1; dec_rem = 1'b1; dec_sa = 1'b0; dec_sb = 1'b0; end
            default: ;
        endcase
    end

    logic            src1_neg, src2_neg;
    logic [XLEN-1:0] src1_mag, src2_mag;
    assign src1_neg = dec_sa & src1[XLEN-1];
    assign src2_neg = dec_sb & src2[XLEN-1];
    assign src1_mag = src1_neg ? -src1 : src1;
    assign src2_mag = src2_neg ? -src2 : src2;

    logic            div_by_zero, div_ovf;
    logic [XLEN-1:0] special_res;
    assign div_by_zero = dec_div & (src2 == '0);
    assign div_ovf     = dec_div & dec_sa & (src1 == MinNeg) & (src2 == '1);
    always_comb begin
        special_res = '0;
        if (div_by_zero) begin
            special_res = dec_rem ? src1 : '1;
        end else if (div_ovf) begin
            special_res = dec_rem ? '0 : src1;
        end
    end

    // Multiply step: add multiplicand into the high half when the multiplier LSB is set,
    // then shift the whole accumulator right (multiplier bits drain out of the low half).
    logic [XLEN:0] mul_sum;
    assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

    // Divide step: high half is the partial remainder, low half shifts dividend out and
    // quotient bits in.
    logic [XLEN:0]   div_shift;
    logic [XLEN-1:0] div_trial;
    logic            div_ge;
    assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_ge    = div_shift >= {1'b0, opnd_q};
    assign div_trial = div_shift[XLEN-1:0] - opnd_q;

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;
    assign prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    assign quo_fix  = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem_fix  = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    always_comb begin
        if (is_div_q) begin
            fix_res = is_rem_q ? rem_fix : quo_fix;
        end else begin
            fix_res = is_hi_q ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
        end
    end

    logic accept;
    assign accept = in_valid & (state_q == StIdle) & alu_ctrl[4] & ~flush;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        is_div_d = is_div_q;
        is_rem_d = is_rem_q;
        is_hi_d  = is_hi_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    cnt_d    = '0;
                    is_div_d = dec_div;
                    is_rem_d = dec_rem;
                    is_hi_d  = dec_hi;
                    neg_a_d  = src1_neg;
                    neg_b_d  = src2_neg;
                    if (div_by_zero || div_ovf) begin
                        result_d = special_res;
                        state_d  = StDone;
                    end else if (dec_div) begin
                        acc_d   = {{XLEN{1'b0}}, src1_mag};
                        opnd_d  = src2_mag;
                        state_d = StDiv;
                    end else begin
                        acc_d   = {{XLEN{1'b0}}, src2_mag};
                        opnd_d  = src1_mag;
                        state_d = StMul;
                    end
                end
            end
            StMul: begin
                acc_d = {mul_sum, acc_q[XLEN-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LastIter) state_d = StFix;
            end
            StDiv: begin
                acc_d = {(div_ge ? div_trial : div_shift[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LastIter) state_d = StFix;
            end
            StFix: begin
                result_d = fix_res;
                state_d  = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // A killed op never reaches DONE, so its result is never published.
        if (flush && (state_q != StIdle)) begin
            state_d  = StIdle;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            result_q <= '0;
            is_div_q <= 1'b0;
            is_rem_q <= 1'b0;
            is_hi_q  <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
            is_div_q <= is_div_d;
            is_rem_q <= is_rem_d;
            is_hi_q  <= is_hi_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = result_q;

endmodule

// File: tb/tb_core_muldiv_ctrl.sv
// Bench for core_muldiv_ctrl: directed vector table, flush/reset/ignore sequences and
// randomized ops checked against a plain-arithmetic reference model.
module tb_core_muldiv_ctrl;

    localparam logic [4:0] OP_MUL   = 5'b10000;
    localparam logic [4:0] OP_MULH  = 5'b10001;
    localparam logic [4:0] OP_MULSU = 5'b10011;
    localparam logic [4:0] OP_MULHU = 5'b10010;
    localparam logic [4:0] OP_DIV   = 5'b10110;
    localparam logic [4:0] OP_DIVU  = 5'b10100;
    localparam logic [4:0] OP_REM   = 5'b10101;
    localparam logic [4:0] OP_REMU  = 5'b10111;
    localparam logic [63:0] MIN     = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  alu_ctrl = '0;
    logic [63:0] src1 = '0;
    logic [63:0] src2 = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        out_valid;
    logic [63:0] result;

    core_muldiv_ctrl #(.XLEN(64), .CNT_W(7)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .src1      (src1),
        .src2      (src2),
        .flush     (flush),
        .busy      (busy),
        .out_valid (out_valid),
        .result    (result)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    logic [63:0] last_exp = '0;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] ref_model(input logic [4:0] op, input logic [63:0] a,
                                              input logic [63:0] b);
        logic signed [63:0] sa, sb, sq;
        logic [127:0] ea, eb, ua, ub, p;
        sa = a;
        sb = b;
        ea = {{64{a[63]}}, a};
        eb = {{64{b[63]}}, b};
        ua = {64'b0, a};
        ub = {64'b0, b};
        case (op)
            OP_MUL:   begin p = ea * eb; return p[63:0];   end
            OP_MULH:  begin p = ea * eb; return p[127:64]; end
            OP_MULSU: begin p = ea * ub; return p[127:64]; end
            OP_MULHU: begin p = ua * ub; return p[127:64]; end
            OP_DIV: begin
                if (b == 64'd0) return ONES;
                if (a == MIN && b == ONES) return a;
                sq = sa / sb;
                return sq;
            end
            OP_DIVU: return (b == 64'd0) ? ONES : a / b;
            OP_REM: begin
                if (b == 64'd0) return a;
                if (a == MIN && b == ONES) return 64'd0;
                sq = sa % sb;
                return sq;
            end
            OP_REMU: return (b == 64'd0) ? a : a % b;
            default: return 64'd0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [4:0] op, input logic [63:0] a,
                                       input logic [63:0] b);
        if (op == OP_DIV || op == OP_DIVU || op == OP_REM || op == OP_REMU) begin
            if (b == 64'd0) return 1;
            if ((op == OP_DIV || op == OP_REM) && a == MIN && b == ONES) return 1;
        end
        return 66;
    endfunction

    // Issue one op and follow it to completion, checking result, latency and handshakes.
    task automatic do_op(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp, input int exp_lat, input string name);
        int lat;
        logic busy_ok;
        @(negedge clk);
        in_valid = 1'b1;
        alu_ctrl = op;
        src1     = a;
        src2     = b;
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 0;
        busy_ok  = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            if (!busy || in_ready) busy_ok = 1'b0;
            if (out_valid) begin
                lat = n;
                break;
            end
            @(negedge clk);
        end
        check64({name, " result"}, result, exp);
        check64({name, " latency"}, 64'(lat), 64'(exp_lat));
        check64({name, " busy while in flight"}, {63'b0, busy_ok}, 64'd1);
        @(negedge clk);
        check64({name, " ready/valid after done"}, {62'b0, in_ready, out_valid}, 64'd2);
        last_exp = exp;
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
        string       name;
    } vec_t;

    function automatic logic [63:0] rnd_opnd();
        case ($urandom_range(0, 6))
            0:       return 64'd0;
            1:       return ONES;
            2:       return MIN;
            3:       return 64'($urandom_range(0, 20));
            4:       return -64'($urandom_range(1, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        vec_t vecs[12];
        logic [4:0] ops[8];
        int nv;
        vecs[0]  = '{OP_MUL,   64'd7,    -64'd3, 64'hFFFF_FFFF_FFFF_FFEB, 66, "MUL 7*-3"};
        vecs[1]  = '{OP_MULH,  ONES,     ONES,   64'd0,                   66, "MULH -1*-1"};
        vecs[2]  = '{OP_MULHU, ONES,     64'd2,  64'd1,                   66, "MULHU max*2"};
        vecs[3]  = '{OP_MULSU, ONES,     64'd2,  ONES,                    66, "MULSU -1*2"};
        vecs[4]  = '{OP_DIV,   -64'd7,   64'd2,  64'hFFFF_FFFF_FFFF_FFFD, 66, "DIV -7/2"};
        vecs[5]  = '{OP_REM,   -64'd7,   64'd2,  ONES,                    66, "REM -7/2"};
        vecs[6]  = '{OP_DIVU,  64'd100,  64'd7,  64'd14,                  66, "DIVU 100/7"};
        vecs[7]  = '{OP_REMU,  64'd100,  64'd7,  64'd2,                   66, "REMU 100/7"};
        vecs[8]  = '{OP_DIVU,  64'd5,    64'd0,  ONES,                    1,  "DIVU 5/0"};
        vecs[9]  = '{OP_REM,   64'd5,    64'd0,  64'd5,                   1,  "REM 5/0"};
        vecs[10] = '{OP_DIV,   MIN,      ONES,   MIN,                     1,  "DIV ovf"};
        vecs[11] = '{OP_REM,   MIN,      ONES,   64'd0,                   1,  "REM ovf"};
        ops = '{OP_MUL, OP_MULH, OP_MULSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};

        #1 rst = 1'b1;
        #3;
        check64("reset state", {60'b0, in_ready, busy, out_valid, 1'b0}, 64'h8);
        check64("reset result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].name);
        end

        // Flush at T+20 of a divide: back to idle at T+21, nothing published.
        @(negedge clk);
        in_valid = 1'b1;
        alu_ctrl = OP_DIV;
        src1     = -64'd7;
        src2     = 64'd2;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (19) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check64("flush idle", {62'b0, in_ready, busy}, 64'd2);
        nv = 0;
        for (int i = 0; i < 80; i++) begin
            if (out_valid) nv++;
            @(negedge clk);
        end
        check64("flush no out_valid", 64'(nv), 64'd0);
        check64("flush result held", result, last_exp);
        do_op(OP_MUL, 64'd3, 64'd4, 64'd12, 66, "MUL 3*4 after flush");

        // Flush together with in_valid blocks the accept.
        @(negedge clk);
        in_valid = 1'b1;
        flush    = 1'b1;
        alu_ctrl = OP_DIVU;
        src1     = 64'd100;
        src2     = 64'd7;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        check64("flush+valid no accept", {62'b0, in_ready, busy}, 64'd2);

        // Non-M code is ignored.
        @(negedge clk);
        in_valid = 1'b1;
        alu_ctrl = 5'b00000;
        src1     = 64'd5;
        src2     = 64'd6;
        @(negedge clk);
        in_valid = 1'b0;
        check64("non-M no accept", {62'b0, in_ready, busy}, 64'd2);
        nv = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid) nv++;
            @(negedge clk);
        end
        check64("non-M no out_valid", 64'(nv), 64'd0);
        check64("non-M result held", result, last_exp);

        // Asynchronous reset between edges in the middle of a multiply.
        @(negedge clk);
        in_valid = 1'b1;
        alu_ctrl = OP_MUL;
        src1     = 64'd7;
        src2     = -64'd3;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check64("busy mid-MUL", {63'b0, busy}, 64'd1);
        #2 rst = 1'b1;
        #1;
        check64("async reset state", {60'b0, in_ready, busy, out_valid, 1'b0}, 64'h8);
        check64("async reset result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        last_exp = 64'd0;

        for (int i = 0; i < 30; i++) begin
            logic [4:0]  op;
            logic [63:0] a, b;
            op = ops[$urandom_range(0, 7)];
            a  = rnd_opnd();
            b  = rnd_opnd();
            do_op(op, a, b, ref_model(op, a, b), ref_latency(op, a, b),
                  $sformatf("rand%0d op=%b a=%h b=%h", i, op, a, b));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
